// File: rtl/lcd_controller_pkg.sv
// Shared state encodings and LCD constants for the 4-bit HD44780 controller.
// The CPU decodes its LCD instruction using the opcode field positions below.
package lcd_controller_pkg;

    typedef enum logic [3:0] {
        PWR_WAIT,
        INIT_SETUP,
        INIT_PULSE,
        INIT_WAIT,
        CFG,
        IDLE,
        HI_SETUP,
        HI_PULSE,
        GAP,
        LO_SETUP,
        LO_PULSE,
        BYTE_WAIT
    } lcd_state_e;

    localparam logic [3:0] INIT_NIB_8BIT = 4'h3;
    localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

    localparam logic [7:0] LCD_FUNCSET = 8'h28;
    localparam logic [7:0] LCD_ENTRY   = 8'h06;
    localparam logic [7:0] LCD_DISPON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR   = 8'h01;

    // Bit positions inside the CPU's LCD instruction word.
    localparam int LCD_OP_RS_BIT   = 8;
    localparam int LCD_OP_DATA_MSB = 7;
    localparam int LCD_OP_DATA_LSB = 0;

    function automatic logic [3:0] init_nibble(input logic [1:0] idx);
        return (idx == 2'd3) ? INIT_NIB_4BIT : INIT_NIB_8BIT;
    endfunction

    function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = LCD_FUNCSET;
            2'd1:    b = LCD_ENTRY;
            2'd2:    b = LCD_DISPON;
            default: b = LCD_CLEAR;
        endcase
        return b;
    endfunction

    // Clear and return-home commands need the long execution wait.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] b);
        return !rs && (b == 8'h01 || b == 8'h02 || b == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Down-counter shared by every wait and pulse state of the LCD controller.
// Load (N-1) on state entry; oDone is high while the count sits at zero.
module lcd_delay_timer #(
    parameter int CNT_W = 20
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iLoad,
    input  logic [CNT_W-1:0] iCount,
    output logic             oDone
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt <= '0;
        end else if (iLoad) begin
            cnt <= iCount;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign oDone = (cnt == '0);

endmodule

// File: rtl/lcd_controller.sv
// HD44780 4-bit LCD driver: power-up init, configuration, then one byte per
// accepted CPU request. All LCD timing lives here.
//
//   state      | meaning
//   PWR_WAIT   | power-up delay before the first init nibble
//   INIT_SETUP | init nibble and RS=0 on the bus, E low
//   INIT_PULSE | E high for the init nibble
//   INIT_WAIT  | post-nibble wait (4.1 ms, 100 us, 40 us, 40 us)
//   CFG        | fetch next configuration byte into the byte register
//   IDLE       | ready for a CPU request
//   HI_SETUP   | high nibble and RS on the bus, E low
//   HI_PULSE   | E high for the high nibble
//   GAP        | spacing between the two nibbles of a byte
//   LO_SETUP   | low nibble on the bus, E low
//   LO_PULSE   | E high for the low nibble
//   BYTE_WAIT  | LCD execution time (long for clear/home)
module lcd_controller
    import lcd_controller_pkg::*;
#(
    parameter int T_POWERUP    = 750000,
    parameter int T_4100US     = 205000,
    parameter int T_100US      = 5000,
    parameter int T_40US       = 2000,
    parameter int T_1640US     = 82000,
    parameter int T_EPULSE     = 12,
    parameter int T_NIBBLE_GAP = 50,
    parameter int CNT_W        = 20
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iWrite,
    input  logic       iRS,
    input  logic [7:0] iData,
    output logic       oReady,
    output logic       oLCD_E,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic [3:0] oLCD_Data
);

    localparam logic [CNT_W-1:0] D_POWERUP = CNT_W'(T_POWERUP - 1);
    localparam logic [CNT_W-1:0] D_4100US  = CNT_W'(T_4100US - 1);
    localparam logic [CNT_W-1:0] D_100US   = CNT_W'(T_100US - 1);
    localparam logic [CNT_W-1:0] D_40US    = CNT_W'(T_40US - 1);
    localparam logic [CNT_W-1:0] D_1640US  = CNT_W'(T_1640US - 1);
    localparam logic [CNT_W-1:0] D_EPULSE  = CNT_W'(T_EPULSE - 1);
    localparam logic [CNT_W-1:0] D_GAP     = CNT_W'(T_NIBBLE_GAP - 1);

    lcd_state_e       state, state_nxt;
    logic [1:0]       init_idx, init_idx_nxt;
    logic [1:0]       cfg_idx, cfg_idx_nxt;
    logic             in_cfg, in_cfg_nxt;
    logic             armed;
    logic [7:0]       byte_q, byte_nxt;
    logic             rs_q, rs_nxt;
    logic             ready_q, e_q, lcd_rs_q, lcd_rs_nxt;
    logic [3:0]       lcd_data_q, lcd_data_nxt;
    logic             tmr_load, tmr_done;
    logic [CNT_W-1:0] tmr_count;

    lcd_delay_timer #(.CNT_W(CNT_W)) u_timer (
        .Clock  (Clock),
        .Reset  (Reset),
        .iLoad  (tmr_load),
        .iCount (tmr_count),
        .oDone  (tmr_done)
    );

    always_comb begin
        state_nxt    = state;
        init_idx_nxt = init_idx;
        cfg_idx_nxt  = cfg_idx;
        in_cfg_nxt   = in_cfg;
        byte_nxt     = byte_q;
        rs_nxt       = rs_q;
        case (state)
            // The first cycle after reset only arms the power-up count.
            PWR_WAIT:   if (armed && tmr_done) state_nxt = INIT_SETUP;
            INIT_SETUP: state_nxt = INIT_PULSE;
            INIT_PULSE: if (tmr_done) state_nxt = INIT_WAIT;
            INIT_WAIT: begin
                if (tmr_done) begin
                    if (init_idx == 2'd3) begin
                        cfg_idx_nxt = 2'd0;
                        state_nxt   = CFG;
                    end else begin
                        init_idx_nxt = init_idx + 2'd1;
                        state_nxt    = INIT_SETUP;
                    end
                end
            end
            CFG: begin
                byte_nxt  = cfg_byte(cfg_idx);
                rs_nxt    = 1'b0;
                state_nxt = HI_SETUP;
            end
            IDLE: begin
                if (iWrite) begin
                    byte_nxt  = iData;
                    rs_nxt    = iRS;
                    state_nxt = HI_SETUP;
                end
            end
            HI_SETUP:  state_nxt = HI_PULSE;
            HI_PULSE:  if (tmr_done) state_nxt = GAP;
            GAP:       if (tmr_done) state_nxt = LO_SETUP;
            LO_SETUP:  state_nxt = LO_PULSE;
            LO_PULSE:  if (tmr_done) state_nxt = BYTE_WAIT;
            BYTE_WAIT: begin
                if (tmr_done) begin
                    if (!in_cfg) begin
                        state_nxt = IDLE;
                    end else if (cfg_idx == 2'd3) begin
                        in_cfg_nxt = 1'b0;
                        state_nxt  = IDLE;
                    end else begin
                        cfg_idx_nxt = cfg_idx + 2'd1;
                        state_nxt   = CFG;
                    end
                end
            end
            default: state_nxt = PWR_WAIT;
        endcase
    end

    // Bus values and timer reload are derived from the state being entered.
    always_comb begin
        lcd_rs_nxt   = lcd_rs_q;
        lcd_data_nxt = lcd_data_q;
        tmr_count    = '0;
        case (state_nxt)
            INIT_SETUP: begin
                lcd_rs_nxt   = 1'b0;
                lcd_data_nxt = init_nibble(init_idx_nxt);
            end
            HI_SETUP: begin
                lcd_rs_nxt   = rs_nxt;
                lcd_data_nxt = byte_nxt[7:4];
            end
            LO_SETUP: lcd_data_nxt = byte_q[3:0];
            default:  ;
        endcase
        case (state_nxt)
            PWR_WAIT:                         tmr_count = D_POWERUP;
            INIT_PULSE, HI_PULSE, LO_PULSE:   tmr_count = D_EPULSE;
            INIT_WAIT: begin
                case (init_idx)
                    2'd0:    tmr_count = D_4100US;
                    2'd1:    tmr_count = D_100US;
                    default: tmr_count = D_40US;
                endcase
            end
            GAP:       tmr_count = D_GAP;
            BYTE_WAIT: tmr_count = is_slow_cmd(rs_q, byte_q) ? D_1640US : D_40US;
            default:   tmr_count = '0;
        endcase
        tmr_load = !armed || (state_nxt != state);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= PWR_WAIT;
            init_idx   <= 2'd0;
            cfg_idx    <= 2'd0;
            in_cfg     <= 1'b1;
            armed      <= 1'b0;
            byte_q     <= 8'h00;
            rs_q       <= 1'b0;
            ready_q    <= 1'b0;
            e_q        <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= 4'h0;
        end else begin
            state      <= state_nxt;
            init_idx   <= init_idx_nxt;
            cfg_idx    <= cfg_idx_nxt;
            in_cfg     <= in_cfg_nxt;
            armed      <= 1'b1;
            byte_q     <= byte_nxt;
            rs_q       <= rs_nxt;
            ready_q    <= (state_nxt == IDLE);
            e_q        <= (state_nxt == INIT_PULSE) || (state_nxt == HI_PULSE) ||
                          (state_nxt == LO_PULSE);
            lcd_rs_q   <= lcd_rs_nxt;
            lcd_data_q <= lcd_data_nxt;
        end
    end

    assign oReady    = ready_q;
    assign oLCD_E    = e_q;
    assign oLCD_RS   = lcd_rs_q;
    assign oLCD_RW   = 1'b0;
    assign oLCD_Data = lcd_data_q;

endmodule

// File: tb/tb_lcd_controller.sv
// Bench for lcd_controller with shortened LCD timings: init sequence, byte
// transfers from a vector table plus random bytes, held requests, reset abort.
module tb_lcd_controller;

    localparam int T_POWERUP    = 20;
    localparam int T_4100US     = 10;
    localparam int T_100US      = 5;
    localparam int T_40US       = 4;
    localparam int T_1640US     = 8;
    localparam int T_EPULSE     = 2;
    localparam int T_NIBBLE_GAP = 3;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic [3:0] hi;
        logic [3:0] lo;
        int         wcyc;
        bit         noise;
    } vec_t;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       iWrite = 1'b0;
    logic       iRS = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       oReady, oLCD_E, oLCD_RS, oLCD_RW;
    logic [3:0] oLCD_Data;

    lcd_controller #(
        .T_POWERUP   (T_POWERUP),
        .T_4100US    (T_4100US),
        .T_100US     (T_100US),
        .T_40US      (T_40US),
        .T_1640US    (T_1640US),
        .T_EPULSE    (T_EPULSE),
        .T_NIBBLE_GAP(T_NIBBLE_GAP),
        .CNT_W       (20)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .iWrite   (iWrite),
        .iRS      (iRS),
        .iData    (iData),
        .oReady   (oReady),
        .oLCD_E   (oLCD_E),
        .oLCD_RS  (oLCD_RS),
        .oLCD_RW  (oLCD_RW),
        .oLCD_Data(oLCD_Data)
    );

    always #5 Clock = ~Clock;

    int   n_vec = 0;
    int   n_err = 0;
    int   e_rises = 0;
    logic e_prev = 1'b0;
    logic [3:0] init_seq [12];
    vec_t vecs [$];

    always @(negedge Clock) begin
        if (oLCD_E && !e_prev) e_rises++;
        e_prev = oLCD_E;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Expected BYTE_WAIT length from the command rules.
    function automatic int ref_wait(input logic rs, input logic [7:0] d);
        return (!rs && d >= 8'd1 && d <= 8'd3) ? T_1640US : T_40US;
    endfunction

    task automatic wait_pulse(output logic [3:0] nib, output logic rs,
                              output int width, output bit ok);
        int n;
        logic [3:0] pd;
        logic prs;
        nib = 4'h0; rs = 1'b0; width = 0; ok = 1'b0;
        n = 0; pd = oLCD_Data; prs = oLCD_RS;
        @(negedge Clock);
        while (!oLCD_E && n < 200) begin
            pd = oLCD_Data; prs = oLCD_RS;
            @(negedge Clock);
            n++;
        end
        if (!oLCD_E) begin
            n_vec++; n_err++;
            $display("FAIL pulse_timeout: no E pulse within %0d cycles", n);
            width = -1;
            return;
        end
        nib = oLCD_Data; rs = oLCD_RS;
        ok = (pd == nib) && (prs == rs);
        while (oLCD_E && width < 100) begin
            if (oLCD_Data != nib || oLCD_RS != rs) ok = 1'b0;
            width++;
            @(negedge Clock);
        end
        if (oLCD_Data != nib || oLCD_RS != rs) ok = 1'b0;
    endtask

    task automatic expect_pulse(input string name, input logic rs, input logic [3:0] nib);
        logic [3:0] a_nib;
        logic a_rs;
        int w;
        bit ok;
        wait_pulse(a_nib, a_rs, w, ok);
        check({name, "_rs_nibble"}, int'({a_rs, a_nib}), int'({rs, nib}));
        check({name, "_e_width"}, w, T_EPULSE);
        check({name, "_setup_hold"}, int'(ok), 1);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!oReady && n < 300) begin
            @(negedge Clock);
            n++;
        end
        if (!oReady) begin
            n_vec++; n_err++;
            $display("FAIL ready_timeout: oReady still 0 after %0d cycles", n);
        end
    endtask

    task automatic idle_quiet(input int cycles);
        int r0;
        r0 = e_rises;
        repeat (cycles) @(negedge Clock);
        check("idle_no_pulse", e_rises - r0, 0);
        check("idle_ready", int'(oReady), 1);
    endtask

    // Assumes acceptance happened on the previous rising edge.
    task automatic check_byte(input logic rs, input logic [7:0] d, input logic [3:0] hi,
                              input logic [3:0] lo, input int wcyc, input bit noise);
        int r0, n;
        r0 = e_rises;
        check("ready_drop", int'(oReady), 0);
        expect_pulse("hi", rs, hi);
        if (noise) begin
            iWrite = 1'b1; iRS = ~rs; iData = ~d;
        end
        expect_pulse("lo", rs, lo);
        if (noise) iWrite = 1'b0;
        wait_ready(n);
        check("byte_wait", n, wcyc);
        check("byte_pulses", e_rises - r0, 2);
    endtask

    task automatic send(input vec_t v);
        int n;
        wait_ready(n);
        iWrite = 1'b1; iRS = v.rs; iData = v.data;
        @(negedge Clock);
        iWrite = 1'b0; iRS = 1'($urandom); iData = 8'($urandom);
        check_byte(v.rs, v.data, v.hi, v.lo, v.wcyc, v.noise);
    endtask

    task automatic run_init(input bit noise);
        int r0, n;
        r0 = e_rises;
        for (int i = 0; i < 12; i++) begin
            iWrite = noise && (i < 11) && (i % 2 == 0);
            iRS = 1'($urandom); iData = 8'($urandom);
            expect_pulse("init", 1'b0, init_seq[i]);
            if (i == 10) begin
                n = 0;
                while (oLCD_Data != 4'h1 && n < 20) begin
                    @(negedge Clock);
                    n++;
                end
                check("nibble_gap", n, T_NIBBLE_GAP);
            end
        end
        iWrite = 1'b0;
        wait_ready(n);
        check("init_ready_delay", n, T_1640US);
        check("init_pulses", e_rises - r0, 12);
        idle_quiet(6);
    endtask

    initial begin
        logic [7:0] held [3];
        vec_t v;
        int n;

        init_seq = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
        held = '{8'hA5, 8'h3C, 8'h71};

        vecs.push_back('{1'b1, 8'h48, 4'h4, 4'h8, 4, 1'b0});
        vecs.push_back('{1'b0, 8'h01, 4'h0, 4'h1, 8, 1'b0});
        vecs.push_back('{1'b1, 8'h01, 4'h0, 4'h1, 4, 1'b0});
        vecs.push_back('{1'b0, 8'h02, 4'h0, 4'h2, 8, 1'b1});
        vecs.push_back('{1'b0, 8'h03, 4'h0, 4'h3, 8, 1'b0});
        vecs.push_back('{1'b0, 8'h04, 4'h0, 4'h4, 4, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 4'h0, 4'h0, 4, 1'b1});
        vecs.push_back('{1'b1, 8'hFF, 4'hF, 4'hF, 4, 1'b0});
        for (int i = 0; i < 16; i++) begin
            v.rs    = 1'($urandom_range(0, 1));
            v.data  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            v.hi    = 4'(v.data / 16);
            v.lo    = 4'(v.data % 16);
            v.wcyc  = ref_wait(v.rs, v.data);
            v.noise = 1'($urandom_range(0, 1));
            vecs.push_back(v);
        end

        #2 Reset = 1'b0;
        repeat (3) @(negedge Clock);
        check("rst_ready", int'(oReady), 0);
        check("rst_e", int'(oLCD_E), 0);
        check("rst_rs", int'(oLCD_RS), 0);
        check("rst_rw", int'(oLCD_RW), 0);
        check("rst_data", int'(oLCD_Data), 0);
        Reset = 1'b1;

        run_init(1'b1);

        foreach (vecs[i]) send(vecs[i]);

        wait_ready(n);
        iWrite = 1'b1; iRS = 1'b1; iData = held[0];
        for (int k = 0; k < 3; k++) begin
            wait_ready(n);
            @(negedge Clock);
            if (k < 2) iData = held[k + 1];
            else iWrite = 1'b0;
            check_byte(1'b1, held[k], 4'(held[k] / 16), 4'(held[k] % 16), T_40US, 1'b0);
        end
        idle_quiet(6);

        wait_ready(n);
        iWrite = 1'b1; iRS = 1'b1; iData = 8'h5A;
        @(negedge Clock);
        iWrite = 1'b0;
        n = 0;
        while (!oLCD_E && n < 20) begin
            @(negedge Clock);
            n++;
        end
        check("abort_reached_pulse", int'(oLCD_E), 1);
        #1 Reset = 1'b0;
        #1;
        check("async_rst_e", int'(oLCD_E), 0);
        check("async_rst_ready", int'(oReady), 0);
        check("async_rst_rs_data", int'({oLCD_RS, oLCD_Data}), 0);
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        run_init(1'b0);
        send(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_controller.md
Name: lcd_controller

Overview:
- Drives the 4-bit HD44780-style character LCD on behalf of the CPU's LCD instruction: power-up init, configuration, then one byte (command or character) per accepted request.
- Sits between the CPU execute stage and the board LCD pins. The CPU holds its LCD instruction (stalls) while oReady=0.
- Owns all LCD timing; software only issues bytes.

Parameters:
- T_POWERUP, 750000, cycles of power-up wait before the first init nibble (15 ms @ 50 MHz)
- T_4100US, 205000, wait after init nibble 0
- T_100US, 5000, wait after init nibble 1
- T_40US, 2000, wait after init nibbles 2/3 and after every normal byte
- T_1640US, 82000, wait after clear/home commands (RS=0, byte 0x01, 0x02 or 0x03)
- T_EPULSE, 12, cycles oLCD_E is held high per nibble
- T_NIBBLE_GAP, 50, cycles between high and low nibble of one byte
- CNT_W, 20, delay counter width; must hold the largest T_* value

Ports:
- Clock  in  1  system clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-low reset
- iWrite  in  1  request strobe; sampled only when oReady=1
- iRS  in  1  0 = command byte, 1 = character data
- iData  in  8  byte to send
- oReady  out  1  registered; 1 = init done, idle, request will be accepted this cycle
- oLCD_E  out  1  LCD enable strobe
- oLCD_RS  out  1  LCD register select
- oLCD_RW  out  1  tied 0 (write only)
- oLCD_Data  out  4  LCD data nibble (D7..D4)

Behaviour:
- Reset asserted, including mid-operation: all outputs 0 immediately, the FSM returns to PWR_WAIT and the counter clears. After release the full init sequence reruns; any pending request is lost.
- Delay semantics: a wait of N occupies exactly N cycles. E high lasts exactly T_EPULSE cycles. Data and RS are stable 1 cycle before E rises (SETUP) and through 1 cycle after E falls.
- States:
  - PWR_WAIT (T_POWERUP)
  - INIT_SETUP, INIT_PULSE, INIT_WAIT for nibbles 3,3,3,2 with RS=0. Waits are T_4100US, T_100US, T_40US, T_40US.
  - CFG: bytes 0x28, 0x06, 0x0C, 0x01 in order, each via the byte sequence with RS=0.
  - IDLE
  - HI_SETUP, HI_PULSE, GAP (T_NIBBLE_GAP), LO_SETUP, LO_PULSE, BYTE_WAIT
- Byte sequence: high nibble iData[7:4] first, then low nibble. BYTE_WAIT is T_1640US if RS=0 and byte is 0x01, 0x02 or 0x03; otherwise T_40US. The final 0x01 of CFG therefore waits T_1640US.
- After the last CFG byte the FSM enters IDLE and oReady rises, registered (first cycle in IDLE).
- IDLE with iWrite=1:
  - iData and iRS are latched.
  - oReady falls the next cycle.
  - The byte sequence starts (HI_SETUP).
- On BYTE_WAIT expiry the FSM returns to IDLE and oReady=1 again.
- iWrite while oReady=0 is ignored: no queue, no error. The CPU must hold the request.
- iWrite held high continuously sends one byte per IDLE visit, never two per acceptance.
- In IDLE, oLCD_E=0; oLCD_RS and oLCD_Data hold their last values.
- Counter: loads (T_x - 1) on state entry, decrements to 0, transition when 0. No wrap; all T_* must be ≥1.

Decomposition:
- Shared defines include, alongside the existing opcode/character definitions:
  - state encodings
  - init nibble constants
  - CFG byte constants (LCD_FUNCSET 0x28, LCD_ENTRY 0x06, LCD_DISPON 0x0C, LCD_CLEAR 0x01)
  - LCD opcode field positions used by the CPU to drive iRS/iData
- Sub-module lcd_delay_timer: inputs Clock, Reset, iLoad, iCount[CNT_W]; output oDone. It is shared by all wait and pulse states.
- The FSM and the nibble mux stay in lcd_controller.

Test Plan (bench overrides T_POWERUP=20, T_4100US=10, T_100US=5, T_40US=4, T_1640US=8, T_EPULSE=2, T_NIBBLE_GAP=3):
- Reset release, idle inputs:
  - E pulses carry nibbles 3,3,3,2 (RS=0), then 2,8,0,6,0,C,0,1.
  - Each E-high is exactly 2 cycles; gap between the final 0 and 1 nibbles of a CFG byte is 3 cycles.
  - oReady rises 8 cycles after the last E falls.
- After oReady, iWrite=1, iRS=1, iData=0x48 ('H'):
  - E pulses carry nibble 4 then 8 with RS=1.
  - oReady is 0 the cycle after acceptance and returns 1 four cycles after the second E falls.
- iRS=0, iData=0x01: BYTE_WAIT lasts 8 cycles. iRS=1, iData=0x01: BYTE_WAIT lasts 4 cycles.
- iWrite pulsed during init and mid-byte: no extra E pulses occur; the in-flight byte is unchanged.
- iWrite held high for 3 bytes with iData changing each acceptance: exactly 3 bytes sent, each using the value present in its acceptance cycle.
- Reset asserted during HI_PULSE: E drops to 0 asynchronously; after release the full init restarts from PWR_WAIT and the aborted byte is never sent.
